// File: rtl/icetap_capture_ctrl.sv
// Capture controller for a circular sample memory: keeps pre-trigger history, then fills the rest after a trigger.
// Optional feature macro: ICETAP_TRIG_COUNT_EN (require N qualifying triggers before post-trigger capture).
module icetap_capture_ctrl #(
    parameter int ADDR_BITS     = 8,
    parameter int TRIG_CNT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     trigger,
    input  logic                     store_valid,
    input  logic [ADDR_BITS-1:0]     pretrig_depth,
    input  logic [TRIG_CNT_BITS-1:0] trig_count,
    output logic                     mem_wr,
    output logic [ADDR_BITS-1:0]     mem_addr,
    output logic [ADDR_BITS-1:0]     trigger_addr,
    output logic [1:0]               state,
    output logic                     done
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_BITS-1:0]   depth_q, depth_d;
    logic [ADDR_BITS:0]     cnt_q, cnt_d;
    logic [ADDR_BITS:0]     cnt_inc;
    logic [ADDR_BITS:0]     post_total;
    logic                   capturing;
    logic                   wr_en;
    logic                   trig_fire;

    // Samples still owed after the pre-trigger window, trigger sample included (1..DEPTH).
    assign post_total = (ADDR_BITS + 1)'(DEPTH) - {1'b0, depth_q};
    assign cnt_inc    = cnt_q + (ADDR_BITS + 1)'(1);
    assign capturing  = (state_q == S_PRETRIG) || (state_q == S_WAIT) || (state_q == S_POST);
    assign wr_en      = capturing && store_valid && !abort;

`ifdef ICETAP_TRIG_COUNT_EN
    logic [TRIG_CNT_BITS-1:0] tcnt_q, tcnt_d;
    logic [TRIG_CNT_BITS-1:0] tlim_q, tlim_d;
    logic [TRIG_CNT_BITS:0]   tneed;

    // A programmed count of zero behaves like one.
    assign tneed     = (tlim_q == '0) ? (TRIG_CNT_BITS + 1)'(1) : {1'b0, tlim_q};
    assign trig_fire = wr_en && trigger && (({1'b0, tcnt_q} + (TRIG_CNT_BITS + 1)'(1)) >= tneed);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            tlim_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            tlim_q <= tlim_d;
        end
    end

    always_comb begin
        tcnt_d = tcnt_q;
        tlim_d = tlim_q;
        if (!abort && ((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
            tcnt_d = '0;
            tlim_d = trig_count;
        end else if ((state_q == S_WAIT) && wr_en && trigger && !trig_fire) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end
`else
    logic unused_trig_count;

    assign unused_trig_count = ^trig_count;
    assign trig_fire         = wr_en && trigger;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            depth_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_addr_q <= trig_addr_d;
            depth_q     <= depth_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_addr_d = trig_addr_q;
        depth_d     = depth_q;
        cnt_d       = cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        wr_ptr_d = '0;
                        depth_d  = pretrig_depth;
                        cnt_d    = '0;
                        state_d  = (pretrig_depth == '0) ? S_WAIT : S_PRETRIG;
                    end
                end
                S_PRETRIG: begin
                    if (wr_en) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == {1'b0, depth_q}) begin
                            cnt_d   = '0;
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (trig_fire) begin
                        trig_addr_d = wr_ptr_q;
                        cnt_d       = (ADDR_BITS + 1)'(1);
                        state_d     = (post_total == (ADDR_BITS + 1)'(1)) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (wr_en) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == post_total) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_PRETRIG:      state = 2'd1;
            S_WAIT:         state = 2'd2;
            S_POST, S_DONE: state = 2'd3;
            default:        state = 2'd0;
        endcase
    end

    assign mem_wr       = wr_en;
    assign mem_addr     = wr_ptr_q;
    assign trigger_addr = trig_addr_q;
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Directed bench for icetap_capture_ctrl with ADDR_BITS=4 (DEPTH=16); expected values are hand-derived.
module tb_icetap_capture_ctrl;
    logic       clk = 1'b0;
    logic       reset, start, abort, trigger, store_valid;
    logic [3:0] pretrig_depth;
    logic [7:0] trig_count;
    logic       mem_wr, done;
    logic [3:0] mem_addr, trigger_addr;
    logic [1:0] state;
    int         total = 0;
    int         bad   = 0;

    icetap_capture_ctrl #(.ADDR_BITS(4), .TRIG_CNT_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .trigger(trigger),
        .store_valid(store_valid), .pretrig_depth(pretrig_depth), .trig_count(trig_count),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .trigger_addr(trigger_addr),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; start = 1; abort = 0; trigger = 0; store_valid = 1;
        pretrig_depth = 4'd4; trig_count = 8'd1;
        cyc(); cyc(); #1;
        check("rst_state", state, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_trig_addr", trigger_addr, 0);
        check("rst_done", done, 0);

        // Basic capture with pre-trigger depth 4, trigger at address 10
        reset = 0; start = 1;
        cyc(); start = 0; #1;
        check("a_state_pre", state, 1);
        check("a_addr0", mem_addr, 0);
        check("a_mem_wr", mem_wr, 1);
        repeat (4) cyc(); #1;
        check("a_state_wait", state, 2);
        check("a_addr4", mem_addr, 4);
        repeat (6) cyc(); #1;
        check("a_addr10", mem_addr, 10);
        trigger = 1; #1;
        check("a_trig_wr", mem_wr, 1);
        cyc(); trigger = 0; #1;
        check("a_state_post", state, 3);
        check("a_trig_addr", trigger_addr, 10);
        check("a_addr11", mem_addr, 11);
        check("a_done0", done, 0);
        repeat (10) cyc(); #1;
        check("a_last_addr", mem_addr, 5);
        check("a_done_early", done, 0);
        cyc(); #1;
        check("a_done", done, 1);
        check("a_done_state", state, 3);
        check("a_done_addr", mem_addr, 6);
        check("a_done_nowr", mem_wr, 0);
        repeat (3) cyc(); #1;
        check("a_hold_addr", mem_addr, 6);
        check("a_hold_trig", trigger_addr, 10);
        check("a_hold_done", done, 1);

        // Trigger during pre-trigger window is ignored
        start = 1; pretrig_depth = 4'd4;
        cyc(); start = 0; trigger = 1; #1;
        check("b_state_pre", state, 1);
        check("b_addr0", mem_addr, 0);
        repeat (3) cyc(); trigger = 0; #1;
        check("b_still_pre", state, 1);
        check("b_addr3", mem_addr, 3);
        cyc(); #1;
        check("b_state_wait", state, 2);
        check("b_addr4", mem_addr, 4);

        // Abort beats simultaneous start and trigger
        abort = 1; start = 1; trigger = 1; #1;
        check("c_abort_nowr", mem_wr, 0);
        cyc(); abort = 0; start = 0; trigger = 0; #1;
        check("c_state_idle", state, 0);
        check("c_addr_held", mem_addr, 4);
        check("c_idle_nowr", mem_wr, 0);
        pretrig_depth = 4'd0; start = 1; store_valid = 0;
        cyc(); start = 0; #1;
        check("c_restart_state", state, 2);
        check("c_restart_addr", mem_addr, 0);

        // Zero pre-trigger depth, unqualified trigger ignored, 16 post-trigger writes
        store_valid = 1;
        cyc();
        store_valid = 0; trigger = 1; #1;
        check("d_unq_nowr", mem_wr, 0);
        cyc(); #1;
        check("d_unq_state", state, 2);
        check("d_unq_addr", mem_addr, 1);
        trigger = 0; store_valid = 1;
        cyc();
        store_valid = 0;
        cyc();
        store_valid = 1; trigger = 1;
        cyc(); trigger = 0; #1;
        check("d_state_post", state, 3);
        check("d_trig_addr", trigger_addr, 2);
        check("d_addr3", mem_addr, 3);
        repeat (14) cyc(); #1;
        check("d_addr_wrap", mem_addr, 1);
        check("d_done_early", done, 0);
        store_valid = 0;
        cyc(); #1;
        check("d_gap_addr", mem_addr, 1);
        check("d_gap_state", state, 3);
        store_valid = 1;
        cyc(); #1;
        check("d_done", done, 1);
        check("d_done_addr", mem_addr, 2);

        // Pre-trigger depth 15: trigger sample alone completes the capture
        pretrig_depth = 4'd15; start = 1;
        cyc(); start = 0;
        repeat (15) cyc(); #1;
        check("e_state_wait", state, 2);
        check("e_addr15", mem_addr, 15);
        trigger = 1;
        cyc(); trigger = 0; #1;
        check("e_done", done, 1);
        check("e_trig_addr", trigger_addr, 15);
        check("e_addr_wrap", mem_addr, 0);

        // Reset in the middle of post-trigger capture
        pretrig_depth = 4'd2; start = 1;
        cyc(); start = 0;
        cyc(); cyc();
        trigger = 1;
        cyc(); trigger = 0;
        cyc(); #1;
        check("f_state_post", state, 3);
        check("f_addr4", mem_addr, 4);
        reset = 1;
        cyc(); #1;
        check("f_rst_state", state, 0);
        check("f_rst_mem_wr", mem_wr, 0);
        check("f_rst_addr", mem_addr, 0);
        check("f_rst_done", done, 0);
        check("f_rst_trig_addr", trigger_addr, 0);
        reset = 0;

`ifdef ICETAP_TRIG_COUNT_EN
        // Third qualifying trigger is the one that counts
        pretrig_depth = 4'd0; trig_count = 8'd3; start = 1;
        cyc(); start = 0;
        repeat (5) cyc();
        trigger = 1;
        cyc(); trigger = 0;
        cyc();
        trigger = 1;
        cyc(); trigger = 0; #1;
        check("g_state_wait", state, 2);
        check("g_addr8", mem_addr, 8);
        cyc();
        trigger = 1;
        cyc(); trigger = 0; #1;
        check("g_state_post", state, 3);
        check("g_trig_addr", trigger_addr, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icetap_capture_ctrl.md
ICETAP_CAPTURE_CTRL -- requirements
Module: icetap_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, sample-memory address width (DEPTH = 2^ADDR_BITS).
REQ-002 SHALL have parameter TRIG_CNT_BITS, default 8, width of trigger-occurrence count (used only with ICETAP_TRIG_COUNT_EN).
REQ-003 SHALL have port clk  input  1  single clock for all logic (src_clk domain).
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle arm request.
REQ-006 SHALL have port abort  input  1  single-cycle cancel request.
REQ-007 SHALL have port trigger  input  1  trigger condition from trigger unit, sampled every cycle.
REQ-008 SHALL have port store_valid  input  1  sample qualifier; a sample is written only when high.
REQ-009 SHALL have port pretrig_depth  input  ADDR_BITS  samples to keep before trigger; latched on accepted start.
REQ-010 SHALL have port trig_count  input  TRIG_CNT_BITS  trigger occurrences required; latched on accepted start.
REQ-011 SHALL have port mem_wr  output  1  sample-memory write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_BITS  sample-memory write address.
REQ-013 SHALL have port trigger_addr  output  ADDR_BITS  address where the trigger sample was written.
REQ-014 SHALL have port state  output  2  current state encoding: IDLE=0, PRETRIG=1, WAIT_TRIG=2, POSTTRIG/DONE per REQ-017.
REQ-015 SHALL have port done  output  1  capture complete, memory contents stable.

Function
REQ-016 SHALL implement states IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE.
REQ-017 SHALL report state as 0 IDLE, 1 PRETRIG, 2 WAIT_TRIG, 3 POSTTRIG or DONE; done distinguishes DONE.
REQ-018 SHALL, on start in IDLE or DONE, clear wr_ptr to 0, latch pretrig_depth/trig_count, enter PRETRIG (or WAIT_TRIG if pretrig_depth==0).
REQ-019 SHALL assert mem_wr combinationally = store_valid in PRETRIG, WAIT_TRIG, POSTTRIG; mem_wr=0 in IDLE and DONE.
REQ-020 SHALL drive mem_addr = wr_ptr; wr_ptr increments by 1 after every write, wrapping DEPTH-1 -> 0.
REQ-021 SHALL count written samples in PRETRIG; leave to WAIT_TRIG in the cycle the pretrig_depth-th sample is written; trigger ignored in PRETRIG.
REQ-022 SHALL, in WAIT_TRIG, on trigger & store_valid: write that sample, latch trigger_addr = wr_ptr, enter POSTTRIG; trigger with store_valid=0 ignored.
REQ-023 SHALL write exactly DEPTH-pretrig_depth samples from trigger sample inclusive; after the last, enter DONE; if DEPTH-pretrig_depth==1, go WAIT_TRIG -> DONE directly.
REQ-024 SHALL hold wr_ptr, trigger_addr, done stable in DONE until start or abort.
REQ-025 SHALL, on abort in any state, enter IDLE next cycle with mem_wr=0 that cycle; abort wins over simultaneous start or trigger.
REQ-026 SHALL ignore start in PRETRIG, WAIT_TRIG, POSTTRIG.

Reset
REQ-027 SHALL on reset: state IDLE, wr_ptr=0, mem_addr=0, trigger_addr=0, done=0, mem_wr=0, counters 0; reset overrides all inputs including start.

Configuration
REQ-028 SHALL, with ICETAP_TRIG_COUNT_EN defined, require trigger&store_valid seen max(trig_count,1) times in WAIT_TRIG before POSTTRIG; trigger_addr = address of the final qualifying sample.
REQ-029 SHALL, without ICETAP_TRIG_COUNT_EN, ignore trig_count (no counter logic) and use the first qualifying trigger.

Verification (ADDR_BITS=4, DEPTH=16)
REQ-030 SHALL cover: reset asserted mid-POSTTRIG -> next cycle state=0, mem_wr=0, mem_addr=0, done=0.
REQ-031 SHALL cover: pretrig_depth=4, start, store_valid=1, trigger at cycle 10 -> trigger_addr=10, 12 post writes ending addr 5 (wrap), done=1.
REQ-032 SHALL cover: pretrig_depth=4, trigger pulsed during PRETRIG cycles 1-3 -> ignored, state=2 after 4 writes.
REQ-033 SHALL cover: pretrig_depth=0, store_valid toggling 1/0, trigger when store_valid=0 -> no transition; next qualifying trigger -> POSTTRIG, 16 total post writes.
REQ-034 SHALL cover: abort and start same cycle in WAIT_TRIG -> state=0, no write that cycle; later start -> mem_addr=0.
REQ-035 SHALL cover (ICETAP_TRIG_COUNT_EN): trig_count=3, three qualifying triggers at addr 5,7,9 -> trigger_addr=9.
